// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and timer width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_arb_pkg;

    // The GNT encodings double as the one-hot grant vector (bit i = requester i).
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } arb_state_e;

    // Width of the mid-packet idle counter; TIMEOUT must fit in it.
    localparam int TMR_W = 8;

endpackage

// File: rtl/uart_arb_timer.sv
// Mid-packet idle counter: counts idle granted cycles and flags when TIMEOUT is reached.
// Latency: expired_o is combinational on the cycle the TIMEOUT-th idle cycle is counted.
// Backpressure: the caller withholds inc_i while the UART FIFO is full, so stalls never count.
module uart_arb_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic expired_o
);
    import uart_arb_pkg::*;

    localparam logic [TMR_W-1:0] LIMIT_M1 = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // The cycle that would take the count to TIMEOUT is the expiry cycle.
    assign expired_o = inc_i & (cnt_q == LIMIT_M1);

    // Next count: restart on any transfer, on leaving a grant, or on expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expired_o) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter giving two byte requesters packet-atomic access to one UART TX FIFO.
// Latency: zero-cycle byte path once granted; one IDLE cycle for arbitration before each packet.
// Backpressure: tx_full drops ready and stalls the grant indefinitely; the optional mid-packet
//               idle timeout (macro UART_TX_ARB_TIMEOUT_EN) revokes a grant whose owner goes quiet.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       tx_full,
    output logic       wr,
    output logic [7:0] w_data,
    output logic [1:0] grant,
    output logic       timeout_err
);
    import uart_arb_pkg::*;

    // TIMEOUT has to be representable in the idle counter and non-zero.
    if (TIMEOUT < 1 || TIMEOUT > ((2 ** TMR_W) - 1)) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT out of range");
    end

    arb_state_e state_q;
    logic       rr_last_q;
    logic       timeout_err_q;

    logic       gnt0;
    logic       gnt1;
    logic       xfer0;
    logic       xfer1;
    logic       xfer_last;
    logic       tmr_expired;

    assign gnt0 = (state_q == ST_GNT0);
    assign gnt1 = (state_q == ST_GNT1);

    // Only the owner sees ready, and only while the FIFO has room.
    assign req0_ready = gnt0 & ~tx_full;
    assign req1_ready = gnt1 & ~tx_full;

    assign xfer0     = req0_valid & req0_ready;
    assign xfer1     = req1_valid & req1_ready;
    assign xfer_last = (xfer0 & req0_last) | (xfer1 & req1_last);

    assign wr     = xfer0 | xfer1;
    assign w_data = xfer0 ? req0_data : (xfer1 ? req1_data : 8'h00);
    assign grant  = {gnt1, gnt0};

    assign timeout_err = timeout_err_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic granted_vld;
    logic tmr_inc;
    logic tmr_clr;

    // An idle cycle is one where the owner has nothing to offer and the FIFO could have taken it.
    assign granted_vld = (gnt0 & req0_valid) | (gnt1 & req1_valid);
    assign tmr_inc     = (gnt0 | gnt1) & ~granted_vld & ~tx_full;
    assign tmr_clr     = wr | ~(gnt0 | gnt1);

    uart_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (tmr_inc),
        .clr_i     (tmr_clr),
        .expired_o (tmr_expired)
    );
`else
    // Without the timeout the owner keeps the grant until it sends its last byte.
    assign tmr_expired = 1'b0;
`endif

    // Arbitration FSM: pick an owner from IDLE, hold it until last byte (or timeout).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_last_q     <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // On contention the requester that did not win last time goes first.
                    if (req0_valid && (!req1_valid || rr_last_q)) begin
                        state_q   <= ST_GNT0;
                        rr_last_q <= 1'b0;
                    end else if (req1_valid) begin
                        state_q   <= ST_GNT1;
                        rr_last_q <= 1'b1;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    if (xfer_last) begin
                        state_q <= ST_IDLE;
                    end else if (tmr_expired) begin
                        state_q       <= ST_IDLE;
                        timeout_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, timeout sequence, random run.
// Latency: n/a (testbench).
// Backpressure: tx_full driven directly by the bench.
module tb_uart_tx_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       tx_full;
    logic       wr;
    logic [7:0] w_data;
    logic [1:0] grant;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_last   (req0_last),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_last   (req1_last),
        .req1_ready  (req1_ready),
        .tx_full     (tx_full),
        .wr          (wr),
        .w_data      (w_data),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       full;
        logic [1:0] g;
        logic       wr_e;
        logic [7:0] wd;
        logic       r0;
        logic       r1;
        logic       err;
    } vec_t;

    function automatic vec_t mk(input logic rst,
                                input logic v0, input logic [7:0] d0, input logic l0,
                                input logic v1, input logic [7:0] d1, input logic l1,
                                input logic full,
                                input logic [1:0] g, input logic wr_e, input logic [7:0] wd,
                                input logic r0, input logic r1, input logic err = 1'b0);
        vec_t v;
        v.rst = rst;  v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1;    v.d1 = d1; v.l1 = l1; v.full = full;
        v.g = g;      v.wr_e = wr_e; v.wd = wd;
        v.r0 = r0;    v.r1 = r1; v.err = err;
        return v;
    endfunction

    task automatic check_outs(input string name, input logic [1:0] e_g, input logic e_wr,
                              input logic [7:0] e_wd, input logic e_r0, input logic e_r1,
                              input logic e_err);
        checks++;
        if ({grant, wr, w_data, req0_ready, req1_ready, timeout_err} !==
            {e_g, e_wr, e_wd, e_r0, e_r1, e_err}) begin
            errors++;
            $display("FAIL %s @%0t: got grant=%b wr=%b w_data=%h rdy0=%b rdy1=%b err=%b, want grant=%b wr=%b w_data=%h rdy0=%b rdy1=%b err=%b",
                     name, $time, grant, wr, w_data, req0_ready, req1_ready, timeout_err,
                     e_g, e_wr, e_wd, e_r0, e_r1, e_err);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance to just after the next edge.
    task automatic apply(input vec_t v, input string name);
        reset      = v.rst;
        req0_valid = v.v0;  req0_data = v.d0;  req0_last = v.l0;
        req1_valid = v.v1;  req1_data = v.d1;  req1_last = v.l1;
        tx_full    = v.full;
        #3;
        check_outs(name, v.g, v.wr_e, v.wd, v.r0, v.r1, v.err);
        @(posedge clk);
        #1;
    endtask

    // Random traffic against a byte/packet-level model of the arbitration rules.
    task automatic run_random();
        logic [8:0] src0[$];
        logic [8:0] src1[$];
        logic [8:0] head;
        int   owner;
        int   last_win;
        int   idle_cnt;
        int   gen_bytes;
        int   dut_wr;
        int   cyc;
        int   len;
        logic pres0;
        logic pres1;
        logic full_r;
        logic m_err;
        logic nxt_err;
        logic vld_o;
        logic e_wr;
        logic [7:0] e_wd;
        logic [1:0] e_g;

        apply(mk(1, 0,8'h00,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0), "rnd_reset");
        owner = -1; last_win = 1; idle_cnt = 0; m_err = 1'b0;
        pres0 = 1'b0; pres1 = 1'b0; cyc = 0; dut_wr = 0; gen_bytes = 0;

        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                src0.push_back({(b == len - 1), 8'($urandom)});
                gen_bytes++;
            end
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                src1.push_back({(b == len - 1), 8'($urandom)});
                gen_bytes++;
            end
        end

        while ((src0.size() > 0 || src1.size() > 0) && cyc < 6000) begin
            // A requester that starts presenting a byte keeps it up until it is taken.
            if (!pres0 && src0.size() > 0 && $urandom_range(0, 3) != 0) pres0 = 1'b1;
            if (!pres1 && src1.size() > 0 && $urandom_range(0, 3) != 0) pres1 = 1'b1;
            full_r = ($urandom_range(0, 3) == 0);

            reset      = 1'b0;
            req0_valid = pres0;
            req0_data  = pres0 ? src0[0][7:0] : 8'($urandom);
            req0_last  = pres0 ? src0[0][8]   : 1'($urandom);
            req1_valid = pres1;
            req1_data  = pres1 ? src1[0][7:0] : 8'($urandom);
            req1_last  = pres1 ? src1[0][8]   : 1'($urandom);
            tx_full    = full_r;

            vld_o = (owner == 0) ? pres0 : ((owner == 1) ? pres1 : 1'b0);
            e_wr  = (owner >= 0) && !full_r && vld_o;
            e_wd  = !e_wr ? 8'h00 : ((owner == 0) ? src0[0][7:0] : src1[0][7:0]);
            e_g   = (owner == 0) ? 2'b01 : ((owner == 1) ? 2'b10 : 2'b00);
            #3;
            check_outs("rnd_cycle", e_g, e_wr, e_wd, (owner == 0) && !full_r,
                       (owner == 1) && !full_r, m_err);
            if (wr === 1'b1) dut_wr++;

            nxt_err = 1'b0;
            if (e_wr) begin
                if (owner == 0) begin
                    head = src0.pop_front();
                    pres0 = 1'b0;
                end else begin
                    head = src1.pop_front();
                    pres1 = 1'b0;
                end
                idle_cnt = 0;
                if (head[8]) owner = -1;
            end else if (owner >= 0) begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                if (!full_r) begin
                    idle_cnt++;
                    if (idle_cnt == TO) begin
                        owner    = -1;
                        idle_cnt = 0;
                        nxt_err  = 1'b1;
                    end
                end
`endif
            end else if (pres0 || pres1) begin
                // Contention goes to whoever was not granted most recently.
                if (pres0 && pres1) owner = 1 - last_win;
                else                owner = pres0 ? 0 : 1;
                last_win = owner;
            end
            m_err = nxt_err;

            @(posedge clk);
            #1;
            cyc++;
        end

        checks++;
        if (src0.size() != 0 || src1.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: bytes left req0=%0d req1=%0d after %0d cycles, want 0 and 0",
                     src0.size(), src1.size(), cyc);
        end
        checks++;
        if (dut_wr != gen_bytes) begin
            errors++;
            $display("FAIL rnd_bytecount: wr strobes=%0d, want %0d", dut_wr, gen_bytes);
        end
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        tx_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then req0 alone sends A1 A2 A3.
        tbl.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0));
        tbl.push_back(mk(0, 1,8'hA1,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0));
        tbl.push_back(mk(0, 1,8'hA1,0, 0,8'h00,0, 0, 2'b01,1,8'hA1,1,0));
        tbl.push_back(mk(0, 1,8'hA2,0, 0,8'h00,0, 0, 2'b01,1,8'hA2,1,0));
        tbl.push_back(mk(0, 1,8'hA3,1, 0,8'h00,0, 0, 2'b01,1,8'hA3,1,0));
        tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0));
        // Reset with both valid: outputs at reset values; then alternation 10,11,20,21 twice.
        tbl.push_back(mk(1, 1,8'h10,0, 1,8'h20,0, 0, 2'b00,0,8'h00,0,0));
        tbl.push_back(mk(0, 1,8'h10,0, 1,8'h20,0, 0, 2'b00,0,8'h00,0,0));
        tbl.push_back(mk(0, 1,8'h10,0, 1,8'h20,0, 0, 2'b01,1,8'h10,1,0));
        tbl.push_back(mk(0, 1,8'h11,1, 1,8'h20,0, 0, 2'b01,1,8'h11,1,0));
        tbl.push_back(mk(0, 1,8'h10,0, 1,8'h20,0, 0, 2'b00,0,8'h00,0,0));
        tbl.push_back(mk(0, 1,8'h10,0, 1,8'h20,0, 0, 2'b10,1,8'h20,0,1));
        tbl.push_back(mk(0, 1,8'h10,0, 1,8'h21,1, 0, 2'b10,1,8'h21,0,1));
        tbl.push_back(mk(0, 1,8'h10,0, 1,8'h20,0, 0, 2'b00,0,8'h00,0,0));
        tbl.push_back(mk(0, 1,8'h10,0, 1,8'h20,0, 0, 2'b01,1,8'h10,1,0));
        tbl.push_back(mk(0, 1,8'h11,1, 1,8'h20,0, 0, 2'b01,1,8'h11,1,0));
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'h20,0, 0, 2'b00,0,8'h00,0,0));
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'h20,0, 0, 2'b10,1,8'h20,0,1));
        // req1 mid-packet stalled by tx_full for 5 cycles, then resumes with 21.
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0,8'h00,0, 1,8'h21,1, 1, 2'b10,0,8'h00,0,0));
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'h21,1, 0, 2'b10,1,8'h21,0,1));
        tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0));
        // req1 raises 55 while req0 owns the FIFO: waits for last byte plus one IDLE cycle.
        tbl.push_back(mk(0, 1,8'h30,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0));
        tbl.push_back(mk(0, 1,8'h30,0, 0,8'h00,0, 0, 2'b01,1,8'h30,1,0));
        tbl.push_back(mk(0, 1,8'h31,0, 1,8'h55,1, 0, 2'b01,1,8'h31,1,0));
        tbl.push_back(mk(0, 1,8'h32,1, 1,8'h55,1, 0, 2'b01,1,8'h32,1,0));
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'h55,1, 0, 2'b00,0,8'h00,0,0));
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'h55,1, 0, 2'b10,1,8'h55,0,1));
        tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0));
        // Reset after first byte of a req0 packet; req1 alone is granted after release.
        tbl.push_back(mk(0, 1,8'hA1,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0));
        tbl.push_back(mk(0, 1,8'hA1,0, 0,8'h00,0, 0, 2'b01,1,8'hA1,1,0));
        tbl.push_back(mk(1, 1,8'hA2,0, 1,8'hB1,1, 0, 2'b00,0,8'h00,0,0));
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'hB1,1, 0, 2'b00,0,8'h00,0,0));
        tbl.push_back(mk(0, 0,8'h00,0, 1,8'hB1,1, 0, 2'b10,1,8'hB1,0,1));
        tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Owner sends one byte without last, then goes quiet for longer than TIMEOUT.
        apply(mk(1, 0,8'h00,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0), "to_reset");
        apply(mk(0, 1,8'hC1,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0), "to_idle");
        apply(mk(0, 1,8'hC1,0, 0,8'h00,0, 0, 2'b01,1,8'hC1,1,0), "to_byte");
        for (int k = 0; k < TO; k++)
            apply(mk(0, 0,8'h00,0, 0,8'h00,0, 0, 2'b01,0,8'h00,1,0), "to_quiet");
`ifdef UART_TX_ARB_TIMEOUT_EN
        apply(mk(0, 0,8'h00,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0,1), "to_revoke");
        apply(mk(0, 0,8'h00,0, 0,8'h00,0, 0, 2'b00,0,8'h00,0,0,0), "to_after");
`else
        for (int k = 0; k < 20; k++)
            apply(mk(0, 0,8'h00,0, 0,8'h00,0, 0, 2'b01,0,8'h00,1,0,0), "to_hold");
`endif

        run_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
